// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM request arbiter: port ids, default widths,
// the {mask,addr,data} request word and the round-robin pointer step.
// No logic of its own.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MASK_W = 4;

    // Round-robin order is the numeric order of these ids.
    localparam logic [1:0] PORT_W0 = 2'd0;
    localparam logic [1:0] PORT_W1 = 2'd1;
    localparam logic [1:0] PORT_R0 = 2'd2;
    localparam logic [1:0] PORT_R1 = 2'd3;

    // Request word as carried on the writer din buses; mask==0 means read.
    typedef struct packed {
        logic [DEF_MASK_W-1:0] mask;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } sram_req_t;

    // Pointer position after a grant to port p: the port following it.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Purpose: in-order 1-bit reader-id FIFO for outstanding SRAM reads.
// Latency: push visible to pop next cycle; empty push+pop bypasses same cycle.
// Backpressure: none internally; caller must not push when full without a pop.
// Ports: clock/reset_n (sync, active-low), push_i/push_dat_i, pop_i/pop_dat_o,
//        full_o, empty_o, count_o (0..DEPTH).
module sram_arb_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     push_dat_i,
    input  logic                     pop_i,
    output logic                     pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;

    // Push and pop on an empty FIFO: the entry passes straight through and
    // is never stored.
    assign bypass    = push_i && pop_i && empty_o;
    assign wr_en     = push_i && !bypass && (!full_o || pop_i);
    assign rd_en     = pop_i && !empty_o;
    assign pop_dat_o = empty_o ? push_dat_i : mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/sram_request_arbiter.sv
// Purpose: round-robin share of one ZBT SRAM controller among W0,W1,R0,R1.
// Latency: accept at N -> sram_addr_valid at N+1; read strobe at M -> r*_data_valid at M+1.
// Backpressure: sram_ready low holds the slot and drops all readys; tag FIFO full blocks reads only.
// Ports: clock, reset_n (sync, active-low); w0/w1 valid/ready/din {mask,addr,data};
//        r0/r1 addr_valid/addr_ready/addr and data_valid/data; sram_* request slot and
//        read return; err_orphan (sticky). Optional ARB_STATS_EN adds stat_grants[63:0],
//        16-bit saturating grant counters {R1,R0,W1,W0}.
module sram_request_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MASK_W    = DEF_MASK_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            w0_valid,
    output logic                            w0_ready,
    input  logic [MASK_W+ADDR_W+DATA_W-1:0] w0_din,
    input  logic                            w1_valid,
    output logic                            w1_ready,
    input  logic [MASK_W+ADDR_W+DATA_W-1:0] w1_din,
    input  logic                            r0_addr_valid,
    output logic                            r0_addr_ready,
    input  logic [ADDR_W-1:0]               r0_addr,
    output logic                            r0_data_valid,
    output logic [DATA_W-1:0]               r0_data,
    input  logic                            r1_addr_valid,
    output logic                            r1_addr_ready,
    input  logic [ADDR_W-1:0]               r1_addr,
    output logic                            r1_data_valid,
    output logic [DATA_W-1:0]               r1_data,
    output logic                            sram_addr_valid,
    input  logic                            sram_ready,
    output logic [ADDR_W-1:0]               sram_addr,
    output logic [DATA_W-1:0]               sram_data_in,
    output logic [MASK_W-1:0]               sram_write_mask,
    input  logic [DATA_W-1:0]               sram_data_out,
    input  logic                            sram_data_out_valid,
    output logic                            err_orphan
`ifdef ARB_STATS_EN
    ,
    output logic [63:0]                     stat_grants
`endif
);
    localparam int DIN_W = MASK_W + ADDR_W + DATA_W;
    localparam int TCW   = $clog2(TAG_DEPTH) + 1;

    logic              slot_vld_q;
    logic [MASK_W-1:0] slot_mask_q;
    logic [ADDR_W-1:0] slot_addr_q;
    logic [DATA_W-1:0] slot_data_q;
    logic              slot_tag_q;
    logic [1:0]        ptr_q;
    logic              r0_vld_q, r1_vld_q, err_q;
    logic [DATA_W-1:0] r0_data_q, r1_data_q;

    logic              slot_free, handoff, tag_push, read_ok, ret_vld, load;
    logic              tag_full, tag_empty, tag_head;
    logic [TCW-1:0]    tag_count;
    logic [3:0]        req_vec;
    logic              gnt_vld;
    logic [1:0]        gnt_id;
    logic [MASK_W-1:0] mask_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              tag_d;

    assign slot_free = !slot_vld_q || sram_ready;
    assign handoff   = slot_vld_q && sram_ready;
    assign tag_push  = handoff && (slot_mask_q == '0);

    // Reads are held back whenever the FIFO would be full after this cycle's
    // push; a same-cycle pop is ignored so the check stays conservative.
    assign read_ok = !tag_full && !(tag_push && tag_count == TCW'(TAG_DEPTH - 1));

    assign req_vec[PORT_W0] = w0_valid;
    assign req_vec[PORT_W1] = w1_valid;
    assign req_vec[PORT_R0] = r0_addr_valid && read_ok;
    assign req_vec[PORT_R1] = r1_addr_valid && read_ok;

    always_comb begin
        logic       hit;
        logic [1:0] idx;
        hit    = 1'b0;
        idx    = ptr_q;
        gnt_id = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!hit && req_vec[idx]) begin
                hit    = 1'b1;
                gnt_id = idx;
            end
        end
        gnt_vld = hit && slot_free && reset_n;
    end

    assign w0_ready      = gnt_vld && (gnt_id == PORT_W0);
    assign w1_ready      = gnt_vld && (gnt_id == PORT_W1);
    assign r0_addr_ready = gnt_vld && (gnt_id == PORT_R0);
    assign r1_addr_ready = gnt_vld && (gnt_id == PORT_R1);

    always_comb begin
        mask_d = '0;
        addr_d = '0;
        data_d = '0;
        tag_d  = 1'b0;
        case (gnt_id)
            PORT_W0: {mask_d, addr_d, data_d} = w0_din[DIN_W-1:0];
            PORT_W1: {mask_d, addr_d, data_d} = w1_din[DIN_W-1:0];
            PORT_R0: addr_d = r0_addr;
            default: begin
                addr_d = r1_addr;
                tag_d  = 1'b1;
            end
        endcase
    end

    // A writer presenting mask==0 is accepted but its request is discarded.
    assign load = gnt_vld && (gnt_id[1] || (mask_d != '0));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            slot_vld_q  <= 1'b0;
            slot_mask_q <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            slot_tag_q  <= 1'b0;
            ptr_q       <= PORT_W0;
        end else begin
            if (load) begin
                slot_vld_q  <= 1'b1;
                slot_mask_q <= mask_d;
                slot_addr_q <= addr_d;
                slot_data_q <= data_d;
                slot_tag_q  <= tag_d;
            end else if (handoff) begin
                slot_vld_q  <= 1'b0;
            end
            if (gnt_vld) begin
                ptr_q <= rr_next(gnt_id);
            end
        end
    end

    assign sram_addr_valid = slot_vld_q;
    assign sram_addr       = slot_addr_q;
    assign sram_data_in    = slot_data_q;
    assign sram_write_mask = slot_mask_q;

    sram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (tag_push),
        .push_dat_i (slot_tag_q),
        .pop_i      (ret_vld),
        .pop_dat_o  (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty),
        .count_o    (tag_count)
    );

    // A strobe with nothing outstanding (not even a same-cycle hand-off) is an orphan.
    assign ret_vld = sram_data_out_valid && (!tag_empty || tag_push);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r0_vld_q  <= 1'b0;
            r1_vld_q  <= 1'b0;
            r0_data_q <= '0;
            r1_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            r0_vld_q <= ret_vld && !tag_head;
            r1_vld_q <= ret_vld && tag_head;
            if (ret_vld && !tag_head) r0_data_q <= sram_data_out;
            if (ret_vld && tag_head)  r1_data_q <= sram_data_out;
            if (sram_data_out_valid && !ret_vld) err_q <= 1'b1;
        end
    end

    assign r0_data_valid = r0_vld_q;
    assign r1_data_valid = r1_vld_q;
    assign r0_data       = r0_data_q;
    assign r1_data       = r1_data_q;
    assign err_orphan    = err_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [4];
    logic [3:0]  acc;
    assign acc = {r1_addr_ready, r0_addr_ready, w1_ready, w0_ready};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    assign stat_grants = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed bench for sram_request_arbiter with a scoreboard: expected SRAM
// requests, read returns and grant ids are queued at stimulus time and popped
// by monitors whenever the DUT presents them.
module tb_sram_request_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int MW = DEF_MASK_W;
    localparam int DIN_W = MW + AW + DW;

    logic clock, reset_n;
    logic w0_valid, w0_ready, w1_valid, w1_ready;
    logic [DIN_W-1:0] w0_din, w1_din;
    logic r0_addr_valid, r0_addr_ready, r0_data_valid;
    logic r1_addr_valid, r1_addr_ready, r1_data_valid;
    logic [AW-1:0] r0_addr, r1_addr, sram_addr;
    logic [DW-1:0] r0_data, r1_data, sram_data_in, sram_data_out;
    logic sram_addr_valid, sram_ready, sram_data_out_valid, err_orphan;
    logic [MW-1:0] sram_write_mask;
`ifdef ARB_STATS_EN
    logic [63:0] stat_grants;
`endif

    sram_request_arbiter dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .w0_valid            (w0_valid),
        .w0_ready            (w0_ready),
        .w0_din              (w0_din),
        .w1_valid            (w1_valid),
        .w1_ready            (w1_ready),
        .w1_din              (w1_din),
        .r0_addr_valid       (r0_addr_valid),
        .r0_addr_ready       (r0_addr_ready),
        .r0_addr             (r0_addr),
        .r0_data_valid       (r0_data_valid),
        .r0_data             (r0_data),
        .r1_addr_valid       (r1_addr_valid),
        .r1_addr_ready       (r1_addr_ready),
        .r1_addr             (r1_addr),
        .r1_data_valid       (r1_data_valid),
        .r1_data             (r1_data),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .err_orphan          (err_orphan)
`ifdef ARB_STATS_EN
        ,
        .stat_grants         (stat_grants)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    sram_req_t  exp_req[$];
    logic [31:0] exp_r0[$];
    logic [31:0] exp_r1[$];
    logic [1:0] exp_gnt[$];
    logic       gnt_mon_en = 1'b0;
    int         gcnt [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: output presented with no expected entry", nm);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_rdy(input string nm, input logic [3:0] exp);
        chk(nm, {r1_addr_ready, r0_addr_ready, w1_ready, w0_ready}, exp);
    endtask

    task automatic idle_inputs();
        w0_valid = 0; w1_valid = 0; r0_addr_valid = 0; r1_addr_valid = 0;
        w0_din = '0; w1_din = '0; r0_addr = '0; r1_addr = '0;
        sram_data_out_valid = 0; sram_data_out = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        repeat (2) step();
        reset_n = 1;
    endtask

    // SRAM request and read-return monitors.
    always @(negedge clock) begin
        if (reset_n) begin
            if (sram_addr_valid && sram_ready) begin
                if (exp_req.size() == 0) unexpected("sram_req");
                else chk("sram_req", {sram_write_mask, sram_addr, sram_data_in}, exp_req.pop_front());
            end
            if (r0_data_valid) begin
                if (exp_r0.size() == 0) unexpected("r0_ret");
                else chk("r0_ret", r0_data, exp_r0.pop_front());
            end
            if (r1_data_valid) begin
                if (exp_r1.size() == 0) unexpected("r1_ret");
                else chk("r1_ret", r1_data, exp_r1.pop_front());
            end
        end
    end

    // Grant monitor: at most one ready; ordered grants while enabled.
    always @(negedge clock) begin : gmon
        logic [3:0] rdys;
        logic [1:0] id;
        if (reset_n) begin
            rdys = {r1_addr_ready, r0_addr_ready, w1_ready, w0_ready};
            chk("ready_onehot", 64'($countones(rdys) <= 1), 64'd1);
            if (gnt_mon_en && rdys != 4'b0) begin
                id = 2'd0;
                for (int k = 0; k < 4; k++) if (rdys[k]) id = 2'(k);
                gcnt[id]++;
                if (exp_gnt.size() == 0) unexpected("gnt_order");
                else chk("gnt_order", id, exp_gnt.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) gcnt[k] = 0;
        sram_ready = 0;

        // Reset: outputs held at zero even with requests and a strobe present.
        reset_n = 0;
        idle_inputs();
        w0_valid = 1; w0_din = {4'hF, 18'h00001, 32'h1};
        r0_addr_valid = 1; sram_data_out_valid = 1;
        repeat (2) step();
        @(negedge clock);
        chk_rdy("rst_readys", 4'b0000);
        chk("rst_slot_vld", sram_addr_valid, 0);
        chk("rst_slot", {sram_write_mask, sram_addr, sram_data_in}, 0);
        chk("rst_ret_vld", {r1_data_valid, r0_data_valid}, 0);
        chk("rst_ret_dat", {r1_data, r0_data}, 0);
        chk("rst_orphan", err_orphan, 0);

        // Single write, latency N -> N+1.
        do_reset();
        sram_ready = 1;
        w0_valid = 1; w0_din = {4'hF, 18'h00010, 32'hDEADBEEF};
        exp_req.push_back({4'hF, 18'h00010, 32'hDEADBEEF});
        @(negedge clock);
        chk_rdy("wr_accept", 4'b0001);
        chk("wr_slot_early", sram_addr_valid, 0);
        step(); w0_valid = 0;
        @(negedge clock);
        chk("wr_slot_vld", sram_addr_valid, 1);
        chk("wr_slot_addr", sram_addr, 18'h00010);
        chk("wr_slot_mask", sram_write_mask, 4'hF);
        chk("wr_slot_data", sram_data_in, 32'hDEADBEEF);
        step();
        @(negedge clock);
        chk("wr_slot_empty", sram_addr_valid, 0);

        // Zero-mask write: accepted, dropped, pointer still advances.
        do_reset();
        sram_ready = 1;
        w0_valid = 1; w0_din = {4'h0, 18'h00020, 32'h12345678};
        w1_valid = 1; w1_din = {4'h8, 18'h00030, 32'h87654321};
        exp_req.push_back({4'h8, 18'h00030, 32'h87654321});
        @(negedge clock);
        chk_rdy("m0_accept", 4'b0001);
        step();
        @(negedge clock);
        chk_rdy("m0_ptr_adv", 4'b0010);
        chk("m0_dropped", sram_addr_valid, 0);
        step(); idle_inputs();
        @(negedge clock);
        chk("m0_w1_slot", sram_addr, 18'h00030);
        step();

        // Fairness: all four requesting, 16 cycles.
        do_reset();
        sram_ready = 1;
        w0_valid = 1; w0_din = {4'hF, 18'h00A00, 32'hA0A0A0A0};
        w1_valid = 1; w1_din = {4'h5, 18'h00B00, 32'hB1B1B1B1};
        r0_addr_valid = 1; r0_addr = 18'h00C00;
        r1_addr_valid = 1; r1_addr = 18'h00D00;
        for (int c = 0; c < 4; c++) begin
            exp_gnt.push_back(PORT_W0); exp_gnt.push_back(PORT_W1);
            exp_gnt.push_back(PORT_R0); exp_gnt.push_back(PORT_R1);
            exp_req.push_back({4'hF, 18'h00A00, 32'hA0A0A0A0});
            exp_req.push_back({4'h5, 18'h00B00, 32'hB1B1B1B1});
            exp_req.push_back({4'h0, 18'h00C00, 32'h0});
            exp_req.push_back({4'h0, 18'h00D00, 32'h0});
        end
        gnt_mon_en = 1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            step();
        end
        gnt_mon_en = 0;
        w0_valid = 0; w1_valid = 0; r0_addr_valid = 0; r1_addr_valid = 0;
        for (int k = 0; k < 4; k++) chk($sformatf("fair_cnt%0d", k), gcnt[k], 4);
        // Drain the eight outstanding reads: tags alternate R0,R1.
        for (int i = 0; i < 8; i++) begin
            sram_data_out_valid = 1;
            sram_data_out = 32'h10000000 + 32'(i);
            if (i % 2 == 0) exp_r0.push_back(32'h10000000 + 32'(i));
            else            exp_r1.push_back(32'h10000000 + 32'(i));
            step();
        end
        sram_data_out_valid = 0;
        repeat (2) step();

        // Read routing: R0 then R1, returns one cycle after each strobe.
        do_reset();
        sram_ready = 1;
        r0_addr_valid = 1; r0_addr = 18'h00100;
        r1_addr_valid = 1; r1_addr = 18'h00200;
        exp_req.push_back({4'h0, 18'h00100, 32'h0});
        exp_req.push_back({4'h0, 18'h00200, 32'h0});
        @(negedge clock);
        chk_rdy("rd_r0_first", 4'b0100);
        step(); r0_addr_valid = 0;
        @(negedge clock);
        chk_rdy("rd_r1_next", 4'b1000);
        step(); r1_addr_valid = 0;
        step();
        sram_data_out_valid = 1; sram_data_out = 32'h11111111;
        exp_r0.push_back(32'h11111111);
        step();
        sram_data_out = 32'h22222222;
        exp_r1.push_back(32'h22222222);
        @(negedge clock);
        chk("rd_ret0", {r1_data_valid, r0_data_valid}, 2'b01);
        step(); sram_data_out_valid = 0;
        @(negedge clock);
        chk("rd_ret1", {r1_data_valid, r0_data_valid}, 2'b10);
        step();
        @(negedge clock);
        chk("rd_pulse_end", {r1_data_valid, r0_data_valid}, 2'b00);

        // Tag FIFO full: 8 reads, 9th blocked while a write proceeds.
        do_reset();
        sram_ready = 1;
        r0_addr_valid = 1; r0_addr = 18'h00300;
        for (int i = 0; i < 8; i++) exp_req.push_back({4'h0, 18'h00300, 32'h0});
        exp_req.push_back({4'h3, 18'h00400, 32'hCAFEF00D});
        exp_req.push_back({4'h0, 18'h00300, 32'h0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk($sformatf("full_fill%0d", i), r0_addr_ready, 1);
            step();
        end
        w1_valid = 1; w1_din = {4'h3, 18'h00400, 32'hCAFEF00D};
        @(negedge clock);
        chk_rdy("full_wr_ok", 4'b0010);
        step(); w1_valid = 0;
        @(negedge clock);
        chk("full_blocked", r0_addr_ready, 0);
        step();
        sram_data_out_valid = 1; sram_data_out = 32'h33333333;
        exp_r0.push_back(32'h33333333);
        @(negedge clock);
        chk("full_pop_cycle", r0_addr_ready, 0);
        step(); sram_data_out_valid = 0;
        @(negedge clock);
        chk("full_after_pop", r0_addr_ready, 1);
        step(); r0_addr_valid = 0;
        repeat (2) step();

        // Stall: slot stable and readys low while sram_ready is low.
        do_reset();
        sram_ready = 0;
        w0_valid = 1; w0_din = {4'hF, 18'h00500, 32'h55AA55AA};
        exp_req.push_back({4'hF, 18'h00500, 32'h55AA55AA});
        exp_req.push_back({4'h1, 18'h00600, 32'h66666666});
        @(negedge clock);
        chk_rdy("stall_load", 4'b0001);
        step();
        w0_valid = 0;
        w1_valid = 1; w1_din = {4'h1, 18'h00600, 32'h66666666};
        r0_addr_valid = 1; r0_addr = 18'h00700;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("stall_slot%0d", i), {sram_addr_valid, sram_write_mask, sram_addr, sram_data_in},
                {1'b1, 4'hF, 18'h00500, 32'h55AA55AA});
            chk_rdy($sformatf("stall_rdy%0d", i), 4'b0000);
            step();
        end
        sram_ready = 1;
        @(negedge clock);
        chk_rdy("stall_refill", 4'b0010);
        step();
        w1_valid = 0; r0_addr_valid = 0;
        @(negedge clock);
        chk("stall_w1_slot", sram_addr, 18'h00600);
        step();

        // Orphan strobe: sticky until reset; reset also discards a held slot.
        sram_data_out_valid = 1; sram_data_out = 32'h77777777;
        step(); sram_data_out_valid = 0;
        @(negedge clock);
        chk("orphan_set", err_orphan, 1);
        chk("orphan_no_ret", {r1_data_valid, r0_data_valid}, 2'b00);
        repeat (3) step();
        @(negedge clock);
        chk("orphan_sticky", err_orphan, 1);
        sram_ready = 0;
        step();
        w0_valid = 1; w0_din = {4'hF, 18'h00800, 32'h88888888};
        step(); w0_valid = 0;
        @(negedge clock);
        chk("midop_loaded", sram_addr_valid, 1);
        reset_n = 0;
        step();
        @(negedge clock);
        chk("orphan_clr", err_orphan, 0);
        chk("midop_slot", {sram_addr_valid, sram_addr}, 0);
        reset_n = 1; sram_ready = 1;
        repeat (2) step();
        @(negedge clock);
        chk("midop_discard", sram_addr_valid, 0);

        chk("q_req_empty", exp_req.size(), 0);
        chk("q_r0_empty", exp_r0.size(), 0);
        chk("q_r1_empty", exp_r1.size(), 0);
        chk("q_gnt_empty", exp_gnt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_request_arbiter.md
Name: sram_request_arbiter

Overview:
Single-clock arbiter that shares one ZBT SRAM controller between two writers (W0 image buffer writer, W1 overlay writer) and two readers (R0 image buffer reader, R1 spare/feature reader).
- Requests are granted round-robin and held in one registered request slot toward the SRAM controller.
- Read returns are routed back to the issuing reader through an in-order tag FIFO.
- Sits between the 50 MHz pixel-side producers/consumers and the SRAM controller, in the 50 MHz domain.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 32, SRAM data width
MASK_W, 4, byte write mask width; mask==0 encodes a read toward the controller
TAG_DEPTH, 8, max outstanding reads (power of 2, >=2)

Ports:
clock  in  1  sole clock; all logic rising-edge
reset_n  in  1  synchronous reset, active-low
w0_valid  in  1  W0 request valid
w0_ready  out  1  W0 request accepted this cycle when valid&ready
w0_din  in  MASK_W+ADDR_W+DATA_W  {mask,addr,data}
w1_valid / w1_ready / w1_din  same as W0, for W1
r0_addr_valid  in  1  R0 read request valid
r0_addr_ready  out  1  R0 read accepted when valid&ready
r0_addr  in  ADDR_W  R0 read address
r0_data_valid  out  1  one-cycle pulse, returned data for R0
r0_data  out  DATA_W  R0 return data
r1_addr_valid / r1_addr_ready / r1_addr / r1_data_valid / r1_data  same as R0, for R1
sram_addr_valid  out  1  request slot occupied
sram_ready  in  1  controller accepts slot when addr_valid&ready
sram_addr  out  ADDR_W  request address
sram_data_in  out  DATA_W  write data (0 for reads)
sram_write_mask  out  MASK_W  write mask; 0 for reads
sram_data_out  in  DATA_W  read return data
sram_data_out_valid  in  1  read return strobe, in issue order
err_orphan  out  1  sticky: return strobe arrived with no outstanding tag

Behaviour:
- Reset (reset_n==0 at a clock edge):
  - All outputs are 0: all readys, data_valids, sram_addr_valid, sram_addr/data_in/write_mask, err_orphan.
  - RR pointer is set to W0; tag FIFO is emptied.
  - Reset mid-operation discards the held slot and all outstanding tags.
- Request slot: one register. It is "free" when empty, or when sram_addr_valid&sram_ready this cycle (pass-through refill, full throughput of 1 req/cycle).
- Arbitration: combinational round-robin over order W0,W1,R0,R1, starting at the pointer.
  - A read candidate is eligible only if the tag FIFO is not full, counting pushes this cycle.
  - Exactly one grant per cycle, and only when the slot is free.
  - The granted port's ready is 1; every other ready is 0. Ready never asserts without the slot being free.
- On grant: the slot loads next cycle (accept at N → sram_addr_valid at N+1). The pointer moves to the port after the granted one. With no grant, the pointer holds.
- Writer request with mask==0 is accepted (ready=1) and dropped: the slot is not loaded and the pointer still advances.
- The slot holds stable while sram_addr_valid&!sram_ready.
- Tag FIFO:
  - Push port id (0=R0, 1=R1) when a read slot is handed off (sram_addr_valid&sram_ready&mask==0).
  - Pop on sram_data_out_valid.
  - Simultaneous push and pop are legal; the count is unchanged.
  - Full: reads are ineligible, writes continue.
- Read return:
  - Registered. sram_data_out_valid at cycle M → r{tag}_data_valid=1 and r{tag}_data=sram_data_out at M+1, for one cycle.
  - The other reader's data_valid stays 0.
  - No backpressure: readers must sink every pulse.
- Orphan: sram_data_out_valid with the FIFO empty (and no same-cycle push) → data dropped, err_orphan=1 until reset.
- Fairness: with all four ports requesting continuously and sram_ready=1, each port is granted once every 4 cycles.

Optional Feature:
ARB_STATS_EN
- Defined: adds output stat_grants[63:0], four 16-bit saturating grant counters {R1,R0,W1,W0}. Each counter increments on its port's valid&ready and clears on reset.
- Undefined: no port, no counters.

Decomposition:
- Package sram_arb_pkg holds:
  - port id constants PORT_W0..PORT_R1;
  - ADDR_W/DATA_W/MASK_W defaults;
  - the request struct {mask,addr,data};
  - function rr_next().
- Sub-module sram_arb_tag_fifo: 1-bit wide, TAG_DEPTH deep, synchronous FIFO with full/empty/count.

Test Plan:
- W0 {4'hF,18'h00010,32'hDEADBEEF}, sram_ready=1 → w0_ready at N, sram_addr_valid/addr 18'h00010/mask 4'hF/data DEADBEEF at N+1.
- All four valid continuously, sram_ready=1, 16 cycles → grant order W0,W1,R0,R1 repeating, 4 grants each.
- R0 read 18'h00100, R1 read 18'h00200; controller returns 32'h11111111 then 32'h22222222 → r0_data_valid with 11111111 first, then r1_data_valid with 22222222, each 1 cycle after its strobe.
- Issue 8 reads with no returns → 9th read blocked (ready=0) while a W1 write is still granted; one return → read granted next.
- sram_ready=0 for 5 cycles with slot loaded → slot fields stable, all readys 0; strobe with empty FIFO → err_orphan=1 until reset_n=0.
